vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Free-running 640x480@60 VGA raster timing source, one stage upstream of the sprite/ROM draw stages.
//  Produces DrawX/DrawY pixel coordinates, active-low hs/vs and an active-high visible-area flag (blank=1 -> draw).
//  Also produces a per-frame start pulse and a frame counter for animation logic.
//  Downstream draw stages consume DrawX/DrawY, blank and vga_clk directly.
// PARAMETERS
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch (clocks)
//  H_SYNC     96   horizontal sync width (clocks)
//  H_BACK     48   horizontal back porch; H_TOTAL = sum = 800
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BACK     33   vertical back porch; V_TOTAL = sum = 525
// PORTS
//  vga_clk      in   1   pixel clock (25 MHz); one pixel per rising edge
//  reset        in   1   asynchronous, active-high reset
//  DrawX        out  10  current column, 0..H_TOTAL-1
//  DrawY        out  10  current line, 0..V_TOTAL-1
//  hs           out  1   horizontal sync, active low
//  vs           out  1   vertical sync, active low
//  blank        out  1   1 = (DrawX,DrawY) in visible area, 0 = porch/sync
//  frame_start  out  1   one-cycle pulse while (DrawX,DrawY) == (0,0)
//  frame_count  out  8   completed-frame counter, wraps 255->0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (vga_clk, reset).
//  - Reset (async assert): DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524), hs=1, vs=1, blank=0,
//    frame_start=0, frame_count=8'hFF. Held while reset=1.
//  - First rising edge after release: position (0,0), blank=1, frame_start=1, frame_count=0.
//  - Counters: DrawX += 1 each edge; at H_TOTAL-1 wraps to 0 and DrawY += 1.
//    DrawY wraps V_TOTAL-1 -> 0 on the same edge DrawX wraps. No other states; no stall input.
//  - All outputs registered and coherent: hs/vs/blank/frame_start describe the DrawX/DrawY
//    value present in the same cycle (decoded from next-position values, zero relative skew).
//  - hs=0 iff DrawX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
//  - vs=0 iff DrawY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], full lines.
//  - blank=1 iff DrawX<H_VISIBLE && DrawY<V_VISIBLE.
//  - frame_start=1 exactly one cycle per frame (every H_TOTAL*V_TOTAL = 420000 clocks).
//  - frame_count increments on every edge that enters (0,0); 8-bit wrap, no saturation.
//  - Widths: comparisons unsigned 10-bit; parameters must satisfy H_TOTAL,V_TOTAL <= 1024.
//  - Reset mid-frame: immediate jump to reset values; next edge after release restarts at (0,0).
// CONFIGURATION
//  VGA_SYNC_DELAY_EN defined: hs, vs, blank pass through an extra 2-stage register pipeline
//   so they align with a downstream stage having 1-cycle ROM read + 1-cycle colour register.
//   Pipeline stages reset to idle (hs=1, vs=1, blank=0). DrawX, DrawY, frame_start,
//   frame_count are NOT delayed. After release, blank first rises on edge 3 (not edge 1).
//  VGA_SYNC_DELAY_EN undefined: no pipeline; hs/vs/blank coherent with DrawX/DrawY as above.
// TESTING
//  1. Hold reset 5 cycles -> DrawX=799, DrawY=524, hs=1, vs=1, blank=0, frame_count=FF; release,
//     1 edge -> (0,0), blank=1, frame_start=1, frame_count=0.
//  2. Run one line -> blank falls when DrawX=640; hs=0 for exactly 96 clocks starting at DrawX=656;
//     DrawX 799 -> 0 with DrawY 0 -> 1.
//  3. Run full frame -> vs=0 exactly 1600 clocks (DrawY 490..491); frame_start period 420000;
//     blank=1 count per frame = 307200.
//  4. Run 257 frames -> frame_count sequence 0,1,..,255,0; frame_start never 2 consecutive cycles.
//  5. Assert reset at (DrawX=300,DrawY=200) for 1 cycle -> outputs to reset values asynchronously
//     (before next edge); restart at (0,0).
//  6. With VGA_SYNC_DELAY_EN: hs falls at DrawX=658, blank falls at DrawX=642, DrawX unchanged;
//     without it: 656 and 640.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: pixel position, active-low syncs, visible flag, frame pulse/count.
// Define VGA_SYNC_DELAY_EN to delay hs/vs/blank by two clocks for a ROM + colour-register draw stage.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // Totals must fit the 10-bit position counters (<= 1024).
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    // Flags are decoded from the next position so that, once registered,
    // they describe exactly the DrawX/DrawY value held alongside them.
    always_comb begin
        x_d = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
        hs_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vs_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        blank_d = (x_d < H_VIS) && (y_d < V_VIS);
        fs_d    = (x_d == 10'd0) && (y_d == 10'd0);
        fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 8'hFF;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

`ifdef VGA_SYNC_DELAY_EN
    // Bit 0 is the first delay stage, bit 1 drives the port.
    logic [1:0] hs_pipe_q, vs_pipe_q, blank_pipe_q;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_pipe_q    <= 2'b11;
            vs_pipe_q    <= 2'b11;
            blank_pipe_q <= 2'b00;
        end else begin
            hs_pipe_q    <= {hs_pipe_q[0], hs_q};
            vs_pipe_q    <= {vs_pipe_q[0], vs_q};
            blank_pipe_q <= {blank_pipe_q[0], blank_q};
        end
    end

    assign hs    = hs_pipe_q[1];
    assign vs    = vs_pipe_q[1];
    assign blank = blank_pipe_q[1];
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

endmodule
